// File: rtl/rgbw_spi_master.sv
// SPI mode-0 byte-stream master: frames of bytes are shifted MSB first under
// an active-low chip select, with a minimum cs-high gap between frames.
module rgbw_spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_IDLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       sck,
    output logic       mosi,
    output logic       cs
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        SCK_HI    = 3'd2,
        SCK_LO    = 3'd3,
        WAIT_NEXT = 3'd4,
        GAP       = 3'd5
    } state_t;

    localparam logic [7:0] HP_RELOAD  = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_RELOAD = (CS_IDLE > 0) ? 8'(CS_IDLE - 1) : 8'd0;

    state_t     state_r, state_s;
    logic [7:0] hp_cnt_r, hp_cnt_s;
    logic [2:0] bit_cnt_r, bit_cnt_s;
    logic [7:0] gap_cnt_r, gap_cnt_s;
    logic [7:0] shift_r, shift_s;
    logic       last_r, last_s;
    logic       mosi_r, mosi_s;
    logic       cs_r, cs_s;
    logic       sck_r, sck_s;
    logic       tx_ready_r, tx_ready_s;
    logic       busy_r, busy_s;
    logic       frame_done_r, frame_done_s;
    logic       handshake_s;
    logic       hp_done_s;

    // Handshake is judged against the registered ready the requester actually sees.
    assign handshake_s = tx_valid & tx_ready_r;
    assign hp_done_s   = (hp_cnt_r == 8'd0);

    // Next-state, counters, shifter and next values of the registered outputs.
    always_comb begin
        state_s   = state_r;
        hp_cnt_s  = hp_cnt_r;
        bit_cnt_s = bit_cnt_r;
        gap_cnt_s = gap_cnt_r;
        shift_s   = shift_r;
        last_s    = last_r;
        mosi_s    = mosi_r;

        case (state_r)
            IDLE, WAIT_NEXT: begin
                if (handshake_s) begin
                    state_s   = SETUP;
                    shift_s   = tx_data;
                    mosi_s    = tx_data[7];
                    bit_cnt_s = 3'd7;
                    last_s    = tx_last;
                    hp_cnt_s  = HP_RELOAD;
                end else begin
                    state_s = state_r;
                end
            end
            SETUP: begin
                if (hp_done_s) begin
                    state_s  = SCK_HI;
                    hp_cnt_s = HP_RELOAD;
                end else begin
                    hp_cnt_s = hp_cnt_r - 8'd1;
                end
            end
            SCK_HI: begin
                if (hp_done_s) begin
                    state_s  = SCK_LO;
                    hp_cnt_s = HP_RELOAD;
                    // After bit 0 has been clocked the line simply holds.
                    if (bit_cnt_r != 3'd0) begin
                        shift_s = {shift_r[6:0], 1'b0};
                        mosi_s  = shift_r[6];
                    end else begin
                        mosi_s = mosi_r;
                    end
                end else begin
                    hp_cnt_s = hp_cnt_r - 8'd1;
                end
            end
            SCK_LO: begin
                if (hp_done_s) begin
                    hp_cnt_s = HP_RELOAD;
                    if (bit_cnt_r != 3'd0) begin
                        bit_cnt_s = bit_cnt_r - 3'd1;
                        state_s   = SCK_HI;
                    end else if (last_r) begin
                        state_s   = GAP;
                        gap_cnt_s = GAP_RELOAD;
                    end else begin
                        state_s = WAIT_NEXT;
                    end
                end else begin
                    hp_cnt_s = hp_cnt_r - 8'd1;
                end
            end
            GAP: begin
                if (hp_done_s) begin
                    if (gap_cnt_r == 8'd0) begin
                        state_s = IDLE;
                    end else begin
                        gap_cnt_s = gap_cnt_r - 8'd1;
                        hp_cnt_s  = HP_RELOAD;
                    end
                end else begin
                    hp_cnt_s = hp_cnt_r - 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        cs_s         = (state_s == IDLE) || (state_s == GAP);
        sck_s        = (state_s == SCK_HI);
        tx_ready_s   = (state_s == IDLE) || (state_s == WAIT_NEXT);
        busy_s       = (state_s != IDLE);
        frame_done_s = (state_s == GAP) && (state_r != GAP);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            hp_cnt_r     <= 8'd0;
            bit_cnt_r    <= 3'd0;
            gap_cnt_r    <= 8'd0;
            shift_r      <= 8'd0;
            last_r       <= 1'b0;
            mosi_r       <= 1'b0;
            cs_r         <= 1'b1;
            sck_r        <= 1'b0;
            tx_ready_r   <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            hp_cnt_r     <= hp_cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            gap_cnt_r    <= gap_cnt_s;
            shift_r      <= shift_s;
            last_r       <= last_s;
            mosi_r       <= mosi_s;
            cs_r         <= cs_s;
            sck_r        <= sck_s;
            tx_ready_r   <= tx_ready_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign tx_ready   = tx_ready_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign sck        = sck_r;
    assign mosi       = mosi_r;
    assign cs         = cs_r;

endmodule

// File: tb/tb_rgbw_spi_master.sv
// Scoreboard bench: three masters (CLK_DIV 2, 1, 4) feed slave-side monitors
// that capture bytes on rising sck and compare against queued expectations.
module tb_rgbw_spi_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_last;
    logic [2:0] valid;
    logic [2:0] ready, busy, fdone, sck, mosi, cs;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_byte[$];
    int         exp_len[$];
    logic [7:0] lq1[$], lq2[$];
    logic [7:0] lb[3] = '{8'h00, 8'hFF, 8'h5A};

    always #5 clk = ~clk;

    rgbw_spi_master #(.CLK_DIV(2), .CS_IDLE(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[0]), .tx_last(tx_last),
        .tx_ready(ready[0]), .busy(busy[0]), .frame_done(fdone[0]), .sck(sck[0]), .mosi(mosi[0]), .cs(cs[0]));
    rgbw_spi_master #(.CLK_DIV(1), .CS_IDLE(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[1]), .tx_last(tx_last),
        .tx_ready(ready[1]), .busy(busy[1]), .frame_done(fdone[1]), .sck(sck[1]), .mosi(mosi[1]), .cs(cs[1]));
    rgbw_spi_master #(.CLK_DIV(4), .CS_IDLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[2]), .tx_last(tx_last),
        .tx_ready(ready[2]), .busy(busy[2]), .frame_done(fdone[2]), .sck(sck[2]), .mosi(mosi[2]), .cs(cs[2]));

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Main monitor on the CLK_DIV=2 master: byte capture, frame length, gap, frame_done.
    logic       sck_q = 1'b0, mosi_q = 1'b0, cs_q = 1'b1;
    logic [7:0] sh = 8'd0;
    int         nb = 0, cs_low = 0, cs_high = 1000, fd_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            nb      = 0;
            cs_low  = 0;
            cs_high = 1000;
        end else begin
            if (fdone[0]) fd_cnt++;
            if (sck[0] && !sck_q) begin
                chk("sck_rise_cs_low", cs[0], 1'b0);
                sh = {sh[6:0], mosi[0]};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_byte.size() == 0) chk("unexpected_byte", sh, 32'hFFFF_FFFF);
                    else chk("rx_byte", sh, exp_byte.pop_front());
                end
            end
            if (sck[0] && sck_q) chk("mosi_stable_sck_hi", mosi[0], mosi_q);
            if (!cs[0]) begin
                if (cs_q) chk("cs_gap_min", cs_high >= 4, 1'b1);
                cs_low++;
            end else if (!cs_q) begin
                if (exp_len.size() == 0) chk("unexpected_frame", cs_low, 32'hFFFF_FFFF);
                else chk("cs_low_cycles", cs_low, exp_len.pop_front());
                chk("frame_done_on_cs_rise", fdone[0], 1'b1);
                cs_low  = 0;
                cs_high = 1;
            end else begin
                cs_high++;
            end
        end
        sck_q  = sck[0];
        mosi_q = mosi[0];
        cs_q   = cs[0];
    end

    // Loopback slaves on the CLK_DIV=1 and CLK_DIV=4 masters.
    logic [2:0] lsck_q = 3'b000;
    logic [7:0] lsh[3];
    int         lnb[3] = '{0, 0, 0};
    int         rdy_cnt[3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int k = 1; k < 3; k++) begin
            if (!rst_n) begin
                lnb[k] = 0;
            end else if (sck[k] && !lsck_q[k] && !cs[k]) begin
                lsh[k] = {lsh[k][6:0], mosi[k]};
                lnb[k]++;
                if (lnb[k] == 8) begin
                    lnb[k] = 0;
                    rdy_cnt[k]++;
                    if (k == 1) begin
                        if (lq1.size() == 0) chk("lb1_unexpected", lsh[k], 32'hFFFF_FFFF);
                        else chk("lb1_byte", lsh[k], lq1.pop_front());
                    end else begin
                        if (lq2.size() == 0) chk("lb4_unexpected", lsh[k], 32'hFFFF_FFFF);
                        else chk("lb4_byte", lsh[k], lq2.pop_front());
                    end
                end
            end
            lsck_q[k] = sck[k];
        end
    end

    task automatic send(input int k, input logic [7:0] d, input logic last);
        int n = 0;
        tx_data  = d;
        tx_last  = last;
        valid[k] = 1'b1;
        while (!ready[k] && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready_timeout", ready[k], 1'b1);
        @(posedge clk); #1;
        valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (busy[k] && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", busy[k], 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int rises;
        logic prev;
        rst_n   = 1'b0;
        valid   = 3'b000;
        tx_data = 8'h00;
        tx_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {cs[0], sck[0], mosi[0], ready[0], busy[0], fdone[0]}, 6'b100000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", ready[0], 1'b1);

        // Single byte.
        exp_byte.push_back(8'hA5); exp_len.push_back(34);
        send(0, 8'hA5, 1'b1);

        // Two bytes back to back: one 1-cycle WAIT_NEXT between them.
        exp_byte.push_back(8'h3C); exp_byte.push_back(8'hFF); exp_len.push_back(69);
        send(0, 8'h3C, 1'b0);
        send(0, 8'hFF, 1'b1);

        // Hold off the second byte for 50 cycles in WAIT_NEXT.
        exp_byte.push_back(8'h11); exp_byte.push_back(8'h22); exp_len.push_back(119);
        send(0, 8'h11, 1'b0);
        n = 0;
        while (!ready[0] && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 50; i++) begin
            chk("wait_next_hold", {cs[0], sck[0], ready[0], busy[0]}, 4'b0011);
            @(posedge clk); #1;
        end
        send(0, 8'h22, 1'b1);
        wait_idle(0);

        // Abort 0xF0 after its third rising sck edge.
        send(0, 8'hF0, 1'b1);
        rises = 0;
        n     = 0;
        prev  = sck[0];
        while (rises < 3 && n < 1000) begin
            @(posedge clk); #1;
            if (sck[0] && !prev) rises++;
            prev = sck[0];
            n++;
        end
        chk("abort_third_edge_seen", rises, 3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_outputs", {cs[0], sck[0], mosi[0], ready[0], busy[0], fdone[0]}, 6'b100000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_abort", ready[0], 1'b1);
        exp_byte.push_back(8'h81); exp_len.push_back(34);
        send(0, 8'h81, 1'b1);

        // Two single-byte frames offered continuously: gap enforced by GAP.
        exp_byte.push_back(8'h12); exp_len.push_back(34);
        exp_byte.push_back(8'h34); exp_len.push_back(34);
        send(0, 8'h12, 1'b1);
        send(0, 8'h34, 1'b1);
        wait_idle(0);

        // Loopback at CLK_DIV=1 and CLK_DIV=4.
        for (int k = 1; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (k == 1) lq1.push_back(lb[i]);
                else lq2.push_back(lb[i]);
                send(k, lb[i], 1'b1);
            end
            wait_idle(k);
        end

        repeat (20) @(posedge clk);
        #1;
        chk("bytes_outstanding", exp_byte.size(), 0);
        chk("frames_outstanding", exp_len.size(), 0);
        chk("frame_done_count", fd_cnt, 6);
        chk("lb1_rdy_count", rdy_cnt[1], 3);
        chk("lb4_rdy_count", rdy_cnt[2], 3);
        chk("lb_outstanding", lq1.size() + lq2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgbw_spi_master.md
RGBW_SPI_MASTER -- requirements
Module: rgbw_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, means clk cycles per sck half-period; legal range 1..255.
REQ-002 Parameter CS_IDLE, default 2, means the minimum cs-high gap between frames, in half-periods.
REQ-003 Port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 Port tx_data, input, 8 bits: byte to transmit, MSB first; sampled only at handshake.
REQ-006 Port tx_valid, input, 1 bit: tx_data/tx_last valid.
REQ-007 Port tx_last, input, 1 bit: accepted byte is the final byte of the frame.
REQ-008 Port tx_ready, output, 1 bit: block can accept a byte; handshake = tx_valid & tx_ready at a rising clk edge.
REQ-009 Port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 Port frame_done, output, 1 bit: one-cycle pulse in the cycle cs returns high.
REQ-011 Port sck, output, 1 bit: SPI clock, mode 0 (idles low, data sampled by the slave on rising edge).
REQ-012 Port mosi, output, 1 bit: serial data; changes only while sck is low.
REQ-013 Port cs, output, 1 bit: active-low chip select.
REQ-014 All outputs SHALL be registered.

Function
REQ-015 States: IDLE, SETUP, SCK_HI, SCK_LO, WAIT_NEXT, GAP.
REQ-016 IDLE: cs=1, sck=0, tx_ready=1; handshake -> SETUP; load shifter; set bit counter to 7.
REQ-017 Cycle after handshake: cs=0, mosi=tx_data[7], sck=0.
REQ-018 SETUP SHALL last CLK_DIV cycles with sck=0, then -> SCK_HI.
REQ-019 SCK_HI SHALL last CLK_DIV cycles with sck=1 and mosi stable, then -> SCK_LO.
REQ-020 On entry to SCK_LO, sck=0 and mosi advances to the next lower bit; if the bit just clocked was bit 0, mosi holds.
REQ-021 SCK_LO SHALL last CLK_DIV cycles; then -> SCK_HI if bits remain, else by latched tx_last: 1 -> GAP, 0 -> WAIT_NEXT.
REQ-022 Each byte SHALL produce exactly 8 sck rising edges; cs is low for 17*CLK_DIV cycles per byte.
REQ-023 WAIT_NEXT: cs=0, sck=0, mosi holds, tx_ready=1, indefinitely; handshake -> SETUP with the same timing as REQ-017.
REQ-024 GAP: entered with cs=1 and frame_done=1 for that first cycle; lasts CS_IDLE*CLK_DIV cycles; tx_ready=0; then -> IDLE.
REQ-025 tx_ready SHALL be 0 in SETUP, SCK_HI, SCK_LO and GAP; tx_valid is ignored there and tx_data is not sampled.
REQ-026 Half-period counter width SHALL be 8 bits; bit counter width SHALL be 3 bits; counters SHALL not wrap inside a byte.
REQ-027 CLK_DIV=1 SHALL work: sck = clk/2 during shifting.

Reset
REQ-028 With rst_n=0 at a rising clk edge: state=IDLE, cs=1, sck=0, mosi=0, tx_ready=0, busy=0, frame_done=0, shifter cleared.
REQ-029 tx_ready=1 from the first cycle after rst_n returns high.
REQ-030 Reset mid-byte or mid-frame SHALL abort immediately with no extra sck edge; the partial byte is discarded and no frame_done pulse is produced.

Verification
REQ-031 CLK_DIV=2, single byte 0xA5 with tx_last=1 -> 8 rising sck edges; mosi at edges = 1,0,1,0,0,1,0,1; cs low 34 cycles; one frame_done pulse.
REQ-032 Frame 0x3C then 0xFF (tx_last on second), offered with no gap -> cs continuously low; 16 rising edges; the slave captures 0x3C, 0xFF.
REQ-033 Between two bytes, hold tx_valid low 50 cycles -> cs stays 0, sck stays 0, tx_ready=1, busy=1 throughout.
REQ-034 Reset after the 3rd rising edge of 0xF0 -> next cycle cs=1, sck=0, mosi=0, no frame_done; a subsequent 0x81 is sent correctly.
REQ-035 tx_valid held high with tx_last=1 for two frames (CS_IDLE=2, CLK_DIV=2) -> cs high for at least 4 cycles between frames; second byte accepted only when tx_ready=1.
REQ-036 Loopback into the team's spiSlave at CLK_DIV=1 and at CLK_DIV=4, sending 0x00, 0xFF, 0x5A -> the slave's data output equals each sent byte and rdy_sig pulses once per byte.
